// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fifo_pkg
// Brief    : Word-FIFO defaults and serializer FSM state encodings.
// Revision : 1.0
// ============================================================================
package fifo_pkg;

   localparam int c_fifo_data_width  = 23;
   localparam int c_fifo_count_width = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : baud_tick_gen
// Brief    : Divide-by-BAUD_DIV counter with synchronous restart and tick.
// Revision : 1.0
// ============================================================================
module baud_tick_gen #(
   parameter int BAUD_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic i_restart,
   output logic o_tick
);

   // A one-cycle divider still needs a 1-bit counter that simply stays at 0.
   localparam int                 c_cnt_w = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(BAUD_DIV - 1);

   logic [c_cnt_w-1:0] r_count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_restart || (r_count == c_last)) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/fifo_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_serializer
// Brief    : Pops words from a show-ahead FIFO and sends each as a framed
//            serial stream (start, data LSB first, even parity, stop).
// Revision : 1.0
// ============================================================================
module fifo_serializer
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = c_fifo_data_width,
   parameter int COUNT_WIDTH = c_fifo_count_width,
   parameter int BAUD_DIV    = 4,
   parameter int PARITY_EN   = 1,
   parameter int SENT_WIDTH  = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [DATA_WIDTH-1:0]  head,
   input  logic [COUNT_WIDTH-1:0] fifo_count,
   output logic                   pull,
   output logic                   ser_out,
   output logic                   busy,
   output logic                   frame_done,
   output logic [SENT_WIDTH-1:0]  words_sent
);

   localparam int                 c_bit_w    = $clog2(DATA_WIDTH + 1);
   localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_WIDTH - 1);

   ser_state_t            r_state;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [c_bit_w-1:0]    r_bit_cnt;
   logic                  r_parity;
   logic                  w_tick;
   logic                  w_restart;
   logic                  w_word_ready;
   logic                  w_line;

   assign w_word_ready = enable && (fifo_count != '0);
   assign w_restart    = (r_state == ST_LOAD);

   baud_tick_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clock     (clock),
      .reset     (reset),
      .i_restart (w_restart),
      .o_tick    (w_tick)
   );

   // Line level for the current state; registered into ser_out one cycle later.
   always_comb begin
      w_line = 1'b1;
      case (r_state)
         ST_START:  w_line = 1'b0;
         ST_DATA:   w_line = r_shift[0];
         ST_PARITY: w_line = r_parity;
         default:   w_line = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_parity   <= 1'b0;
         pull       <= 1'b0;
         ser_out    <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         words_sent <= '0;
      end else begin
         pull       <= 1'b0;
         frame_done <= 1'b0;
         ser_out    <= w_line;
         // Leaving STOP still covers the delayed last stop cycle on the line.
         busy       <= (r_state != ST_IDLE) || w_word_ready;

         case (r_state)
            ST_IDLE: begin
               if (w_word_ready) begin
                  r_state <= ST_LOAD;
                  pull    <= 1'b1;
               end
            end
            ST_LOAD: begin
               r_shift  <= head;
               r_parity <= ^head;
               r_state  <= ST_START;
            end
            ST_START: begin
               if (w_tick) begin
                  r_bit_cnt <= '0;
                  r_state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  r_shift <= r_shift >> 1;
                  if (r_bit_cnt == c_last_bit) begin
                     r_state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (w_tick) begin
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_tick) begin
                  frame_done <= 1'b1;
                  words_sent <= words_sent + 1'b1;
                  if (w_word_ready) begin
                     r_state <= ST_LOAD;
                     pull    <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_serializer
// Brief    : Self-checking bench: FIFO model feeding a frame scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fifo_serializer;

   localparam int DW = 23;
   localparam int B  = 4;
   localparam int FB = DW + 1 + 2;
   localparam int FC = FB * B;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [22:0] head;
   logic [4:0]  fifo_count;
   logic        pull, ser_out, busy, frame_done;
   logic [15:0] words_sent;

   logic        en2 = 1'b0;
   logic [22:0] head2;
   logic [4:0]  cnt2;
   logic        pull2, ser2, busy2, fd2;
   logic [3:0]  ws2;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // FIFO model for the default-parameter DUT
   logic [22:0] mem [0:31];
   int          wr = 0;
   int          rd = 0;
   bit          pop_pending = 0;
   int          pull_cnt = 0;
   logic [22:0] sb [$];

   assign head       = mem[rd[4:0]];
   assign fifo_count = 5'(wr - rd);

   // FIFO model for the wrap-test DUT
   int n2_total = 0;
   int n2_pops  = 0;
   bit pop2_pending = 0;

   assign cnt2  = 5'(n2_total - n2_pops);
   assign head2 = 23'(32'(n2_pops) * 32'h0001_3579 ^ 32'h002A_AAAA);

   // Frame monitor state
   logic [FC-1:0] cap;
   int            idx = 0;
   bit            mon_active = 0;
   int            idle_run = 0;
   int            gaps [$];
   int            frames_seen = 0;
   int            fd_cnt = 0;

   fifo_serializer dut (
      .clock      (clk),
      .reset      (rst_n),
      .enable     (enable),
      .head       (head),
      .fifo_count (fifo_count),
      .pull       (pull),
      .ser_out    (ser_out),
      .busy       (busy),
      .frame_done (frame_done),
      .words_sent (words_sent)
   );

   fifo_serializer #(
      .DATA_WIDTH  (23),
      .COUNT_WIDTH (5),
      .BAUD_DIV    (1),
      .PARITY_EN   (0),
      .SENT_WIDTH  (4)
   ) dut2 (
      .clock      (clk),
      .reset      (rst_n),
      .enable     (en2),
      .head       (head2),
      .fifo_count (cnt2),
      .pull       (pull2),
      .ser_out    (ser2),
      .busy       (busy2),
      .frame_done (fd2),
      .words_sent (ws2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [FC-1:0] frame_bits(input logic [22:0] w);
      logic [FC-1:0] f;
      logic          v;
      f = '0;
      for (int b = 0; b < FB; b++) begin
         if (b == 0)            v = 1'b0;
         else if (b <= DW)      v = w[b-1];
         else if (b == DW + 1)  v = ^w;
         else                   v = 1'b1;
         for (int k = 0; k < B; k++) f[b*B+k] = v;
      end
      return f;
   endfunction

   // FIFO models: a pull seen mid-cycle pops on the following edge,
   // so the read pointer moves at the next falling edge.
   always @(negedge clk) begin
      if (pop_pending) begin
         rd = rd + 1;
         pop_pending = 0;
      end
      if (pop2_pending) begin
         n2_pops = n2_pops + 1;
         pop2_pending = 0;
      end
      if (rst_n && pull === 1'b1) begin
         n_checks++;
         if (fifo_count == 5'd0) begin
            n_fail++;
            $display("FAIL pull_on_empty: pull=1 with fifo_count=%0d, required count>0", fifo_count);
         end
         sb.push_back(head);
         pull_cnt++;
         pop_pending = 1;
      end
      if (rst_n && pull2 === 1'b1) begin
         n_checks++;
         if (cnt2 == 5'd0) begin
            n_fail++;
            $display("FAIL pull2_on_empty: pull=1 with fifo_count=%0d, required count>0", cnt2);
         end
         pop2_pending = 1;
      end
   end

   // Frame monitor / scoreboard for the default DUT
   always @(negedge clk) begin
      logic [22:0] w;
      if (!rst_n) begin
         mon_active = 0;
         idx        = 0;
         idle_run   = 0;
         sb.delete();
      end else if (!mon_active) begin
         n_checks++;
         if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_done_idle: got %b outside a frame, required 0", frame_done);
         end
         if (ser_out === 1'b0) begin
            mon_active = 1;
            gaps.push_back(idle_run);
            cap    = '0;
            cap[0] = 1'b0;
            idx    = 1;
         end else begin
            idle_run++;
         end
      end else begin
         cap[idx] = ser_out;
         n_checks++;
         if (frame_done !== (idx == FC - 1)) begin
            n_fail++;
            $display("FAIL frame_done_pos: got %b at frame cycle %0d, required %b",
                     frame_done, idx, (idx == FC - 1));
         end
         if (frame_done === 1'b1) fd_cnt++;
         idx++;
         if (idx == FC) begin
            mon_active = 0;
            idle_run   = 0;
            frames_seen++;
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_frame: got frame %h, required no frame", cap);
            end else begin
               w = sb.pop_front();
               if (cap !== frame_bits(w)) begin
                  n_fail++;
                  $display("FAIL frame_bits word %h: got %h, required %h", w, cap, frame_bits(w));
               end
            end
         end
      end
   end

   task automatic push_word(input logic [22:0] w);
      mem[wr[4:0]] = w;
      wr = wr + 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      enable = 1'b0;
      rst_n  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int t;
      t  = 0;
      ok = 0;
      while (t < budget) begin
         @(negedge clk);
         t++;
         if (busy === 1'b0 && !mon_active && (rd == wr || !enable)) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      int f0;
      f0 = frames_seen;
      rst_n  = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 5; i++) push_word(23'h0A0000 + 23'(i * 23'h011111));
      repeat (8) begin
         @(negedge clk);
         n_checks++;
         if (ser_out !== 1'b1 || pull !== 1'b0 || busy !== 1'b0 ||
             frame_done !== 1'b0 || words_sent !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: got ser=%b pull=%b busy=%b fd=%b ws=%0d, required 1 0 0 0 0",
                     ser_out, pull, busy, frame_done, words_sent);
         end
      end
      rst_n = 1'b1;
      wait_idle(700, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL reset_drain_timeout: got busy=%b, required idle within 700 cycles", busy);
      end
      n_checks++;
      if (words_sent !== 16'd5 || frames_seen - f0 != 5) begin
         n_fail++;
         $display("FAIL reset_drain_count: got ws=%0d frames=%0d, required 5 5",
                  words_sent, frames_seen - f0);
      end
   endtask

   task automatic test_single();
      bit ok;
      int p0, f0, d0;
      do_reset();
      p0 = pull_cnt; f0 = frames_seen; d0 = fd_cnt;
      @(negedge clk);
      push_word(23'h2AAAAA);
      enable = 1'b1;
      @(negedge clk);
      n_checks++;
      if (pull !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_load: got pull=%b busy=%b, required 1 1", pull, busy);
      end
      @(negedge clk);
      n_checks++;
      if (pull !== 1'b0 || ser_out !== 1'b1) begin
         n_fail++;
         $display("FAIL single_load_end: got pull=%b ser=%b, required 0 1", pull, ser_out);
      end
      @(negedge clk);
      n_checks++;
      if (ser_out !== 1'b0) begin
         n_fail++;
         $display("FAIL single_start_edge: got ser=%b, required 0", ser_out);
      end
      wait_idle(200, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_timeout: got busy=%b, required idle within 200 cycles", busy);
      end
      n_checks++;
      if (pull_cnt - p0 != 1 || frames_seen - f0 != 1 || fd_cnt - d0 != 1 || words_sent !== 16'd1) begin
         n_fail++;
         $display("FAIL single_counts: got pulls=%0d frames=%0d fd=%0d ws=%0d, required 1 1 1 1",
                  pull_cnt - p0, frames_seen - f0, fd_cnt - d0, words_sent);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int p0, f0, g0;
      do_reset();
      p0 = pull_cnt; f0 = frames_seen; g0 = gaps.size();
      @(negedge clk);
      push_word(23'h000001);
      push_word(23'h7FFFFF);
      push_word(23'h123456);
      enable = 1'b1;
      wait_idle(500, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL b2b_timeout: got busy=%b, required idle within 500 cycles", busy);
      end
      n_checks++;
      if (pull_cnt - p0 != 3 || frames_seen - f0 != 3 || words_sent !== 16'd3) begin
         n_fail++;
         $display("FAIL b2b_counts: got pulls=%0d frames=%0d ws=%0d, required 3 3 3",
                  pull_cnt - p0, frames_seen - f0, words_sent);
      end
      n_checks++;
      if (gaps.size() - g0 != 3) begin
         n_fail++;
         $display("FAIL b2b_gaps: got %0d frame starts, required 3", gaps.size() - g0);
      end else if (gaps[g0+1] != 1 || gaps[g0+2] != 1) begin
         n_fail++;
         $display("FAIL b2b_gaps: got idle gaps %0d %0d, required 1 1", gaps[g0+1], gaps[g0+2]);
      end
   endtask

   task automatic test_enable_drop();
      bit ok;
      int p0, t;
      do_reset();
      p0 = pull_cnt;
      @(negedge clk);
      push_word(23'h00F0F0);
      push_word(23'h0F0F0F);
      enable = 1'b1;
      t = 0;
      while (!(mon_active && idx >= 20) && t < 60) begin
         @(negedge clk);
         t++;
      end
      enable = 1'b0;
      wait_idle(200, ok);
      repeat (20) @(negedge clk);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL drop_timeout: got busy=%b, required idle within 200 cycles", busy);
      end
      n_checks++;
      if (pull_cnt - p0 != 1 || words_sent !== 16'd1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_counts: got pulls=%0d ws=%0d busy=%b, required 1 1 0",
                  pull_cnt - p0, words_sent, busy);
      end
      enable = 1'b1;
      wait_idle(200, ok);
      n_checks++;
      if (!ok || words_sent !== 16'd2) begin
         n_fail++;
         $display("FAIL drop_resume: got ok=%b ws=%0d, required 1 2", ok, words_sent);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int p0, f0, t;
      do_reset();
      p0 = pull_cnt; f0 = frames_seen;
      @(negedge clk);
      push_word(23'h3C0F0F);
      push_word(23'h05A5A5);
      enable = 1'b1;
      t = 0;
      while (!(mon_active && idx >= 45) && t < 80) begin
         @(negedge clk);
         t++;
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (ser_out !== 1'b1 || busy !== 1'b0 || words_sent !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_mid_immediate: got ser=%b busy=%b ws=%0d, required 1 0 0",
                  ser_out, busy, words_sent);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_idle(200, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL reset_mid_timeout: got busy=%b, required idle within 200 cycles", busy);
      end
      n_checks++;
      if (pull_cnt - p0 != 2 || frames_seen - f0 != 1 || words_sent !== 16'd1) begin
         n_fail++;
         $display("FAIL reset_mid_counts: got pulls=%0d frames=%0d ws=%0d, required 2 1 1",
                  pull_cnt - p0, frames_seen - f0, words_sent);
      end
   endtask

   task automatic test_wrap();
      int t, last_t;
      do_reset();
      en2 = 1'b1;
      repeat (10) begin
         @(negedge clk);
         n_checks++;
         if (pull2 !== 1'b0 || ser2 !== 1'b1 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_idle_pre: got pull=%b ser=%b busy=%b, required 0 1 0", pull2, ser2, busy2);
         end
      end
      n2_total = 17;
      last_t   = 0;
      for (int k = 1; k <= 17; k++) begin
         t = 0;
         while (fd2 !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
         end
         n_checks++;
         if (fd2 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_timeout frame %0d: got no frame_done, required one within 60 cycles", k);
         end else begin
            if (ws2 !== 4'(k % 16)) begin
               n_fail++;
               $display("FAIL wrap_count frame %0d: got %0d, required %0d", k, ws2, k % 16);
            end
            if (k > 1) begin
               n_checks++;
               if (cyc - last_t != 26) begin
                  n_fail++;
                  $display("FAIL wrap_period frame %0d: got %0d cycles, required 26", k, cyc - last_t);
               end
            end
            last_t = cyc;
         end
         @(negedge clk);
      end
      repeat (40) begin
         @(negedge clk);
         n_checks++;
         if (pull2 !== 1'b0 || ser2 !== 1'b1 || busy2 !== 1'b0 || ws2 !== 4'd1) begin
            n_fail++;
            $display("FAIL empty_idle_post: got pull=%b ser=%b busy=%b ws=%0d, required 0 1 0 1",
                     pull2, ser2, busy2, ws2);
         end
      end
      en2 = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid();
      test_wrap();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d pending words, required 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
